// File: rtl/sumador_serial_if.sv
// Request/result bundle for the digit-serial adder/subtractor.
interface sumador_serial_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/sumador_serial.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through one shared slice,
// LSB digit first, with a registered carry and a start/busy/done handshake.
module sumador_serial #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    sumador_serial_if.slave  bus
);
    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned DW = DIGIT + 1;

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
        $error("sumador_serial: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] a_d;
    logic [DIGIT-1:0] b_d;
    logic [DIGIT-1:0] s_d;
    logic             c_out;
    logic             c_msb;
    logic [WIDTH-1:0] res_next;
    logic             last;

    // Shared digit slice; operands shift right so the live digit is always at the bottom.
    assign a_d          = opa[DIGIT-1:0];
    assign b_d          = opb[DIGIT-1:0];
    assign {c_out, s_d} = DW'(a_d) + DW'(b_d) + DW'(carry);
    // Carry into the slice MSB, recovered from its sum bit; only meaningful on the top digit.
    assign c_msb        = s_d[DIGIT-1] ^ a_d[DIGIT-1] ^ b_d[DIGIT-1];
    assign res_next     = (res >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));
    assign last         = (cnt == CW'(N - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            opa          <= '0;
            opb          <= '0;
            res          <= '0;
            carry        <= 1'b0;
            cnt          <= '0;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.sum      <= '0;
            bus.cout     <= 1'b0;
            bus.overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        opa      <= bus.a;
                        opb      <= bus.sub ? ~bus.b : bus.b;
                        carry    <= bus.sub ? 1'b1 : bus.cin;
                        cnt      <= '0;
                        res      <= '0;
                        bus.busy <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        state    <= S_IDLE;
                    end
                end
                S_RUN: begin
                    opa   <= opa >> DIGIT;
                    opb   <= opb >> DIGIT;
                    res   <= res_next;
                    carry <= c_out;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        bus.sum      <= res_next;
                        bus.cout     <= c_out;
                        bus.overflow <= c_msb ^ c_out;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
